control_unit: RTL and testbench



---
 rtl/control_unit.sv | 196 +++++++++++++++++++
 tb/tb_control_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the ARM datapath: emits the 32-bit
// control word per state, waits on MFC with a bounded counter, and traps faults.
module control_unit #(
   parameter int unsigned MFC_TIMEOUT = 16,
   parameter int unsigned ST_W        = 5
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [31:0]     IR,
   input  logic            MFC,
   input  logic [3:0]      Flags,
   output logic [31:0]     CW,
   output logic [ST_W-1:0] STATE,
   output logic            FAULT
);

   localparam logic [ST_W-1:0] S_RST   = ST_W'(0);
   localparam logic [ST_W-1:0] S_F0    = ST_W'(1);
   localparam logic [ST_W-1:0] S_F1    = ST_W'(2);
   localparam logic [ST_W-1:0] S_F2    = ST_W'(3);
   localparam logic [ST_W-1:0] S_DEC   = ST_W'(4);
   localparam logic [ST_W-1:0] S_DP    = ST_W'(5);
   localparam logic [ST_W-1:0] S_LS0   = ST_W'(6);
   localparam logic [ST_W-1:0] S_LD1   = ST_W'(7);
   localparam logic [ST_W-1:0] S_LD2   = ST_W'(8);
   localparam logic [ST_W-1:0] S_ST1   = ST_W'(9);
   localparam logic [ST_W-1:0] S_ST2   = ST_W'(10);
   localparam logic [ST_W-1:0] S_BL    = ST_W'(11);
   localparam logic [ST_W-1:0] S_B     = ST_W'(12);
   localparam logic [ST_W-1:0] S_FAULT = ST_W'(31);

   localparam int B_MFA    = 31;
   localparam int B_RW_RAM = 30;
   localparam int B_RF_RW  = 28;
   localparam int B_SMA    = 25;
   localparam int B_MAR_EN = 23;
   localparam int B_SR_EN  = 22;
   localparam int B_MDR_EN = 21;
   localparam int B_IR_EN  = 20;
   localparam int B_SHT_EN = 19;
   localparam int B_ISE_EN = 18;
   localparam int B_SGN_EN = 17;
   localparam int B_CLR    = 16;

   logic [ST_W-1:0] state, next_state;
   logic [7:0]      wait_cnt;
   logic            in_wait;
   logic            timed_out;
   logic [31:0]     cw;
   logic            unused_ir;

   assign unused_ir = ^{IR[19:5], IR[3:0]};

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      cond_pass = 1'b0;
      case (cond)
         4'h0: cond_pass = z;
         4'h1: cond_pass = ~z;
         4'h2: cond_pass = c;
         4'h3: cond_pass = ~c;
         4'h4: cond_pass = n;
         4'h5: cond_pass = ~n;
         4'h6: cond_pass = v;
         4'h7: cond_pass = ~v;
         4'h8: cond_pass = c & ~z;
         4'h9: cond_pass = ~c | z;
         4'hA: cond_pass = (n == v);
         4'hB: cond_pass = (n != v);
         4'hC: cond_pass = ~z & (n == v);
         4'hD: cond_pass = z | (n != v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   assign in_wait   = (state == S_F1) || (state == S_LD1) || (state == S_ST2);
   assign timed_out = (wait_cnt == 8'(MFC_TIMEOUT));

   // The wait counter restarts whenever the state changes, so every wait state begins at zero
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= S_RST;
         wait_cnt <= '0;
      end else begin
         state <= next_state;
         if (next_state != state)
            wait_cnt <= '0;
         else if (in_wait && !MFC)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_RST: next_state = S_F0;
         S_F0:  next_state = S_F1;
         S_F1:  next_state = MFC ? S_F2 : (timed_out ? S_FAULT : S_F1);
         S_F2:  next_state = S_DEC;
         S_DEC: begin
            if (!cond_pass(IR[31:28], Flags))
               next_state = S_F0;
            else begin
               // 011 with bit 4 set is the architecturally undefined space, not a load/store
               casez (IR[27:25])
                  3'b00?:  next_state = S_DP;
                  3'b010:  next_state = S_LS0;
                  3'b011:  next_state = IR[4] ? S_FAULT : S_LS0;
                  3'b101:  next_state = IR[24] ? S_BL : S_B;
                  default: next_state = S_FAULT;
               endcase
            end
         end
         S_DP:    next_state = S_F0;
         S_LS0:   next_state = IR[20] ? S_LD1 : S_ST1;
         S_LD1:   next_state = MFC ? S_LD2 : (timed_out ? S_FAULT : S_LD1);
         S_LD2:   next_state = S_F0;
         S_ST1:   next_state = S_ST2;
         S_ST2:   next_state = MFC ? S_F0 : (timed_out ? S_FAULT : S_ST2);
         S_BL:    next_state = S_B;
         S_B:     next_state = S_F0;
         S_FAULT: next_state = S_FAULT;
         default: next_state = S_FAULT;
      endcase
   end

   always_comb begin
      cw = '0;
      case (state)
         S_RST: cw[B_CLR] = 1'b1;
         S_F0: begin
            cw[B_MAR_EN] = 1'b1;
            cw[11:10]    = 2'b11;
            cw[3:0]      = 4'b1101;
         end
         S_F1: begin
            cw[B_MFA]    = 1'b1;
            cw[B_RW_RAM] = 1'b1;
            cw[B_MDR_EN] = 1'b1;
            cw[B_RF_RW]  = (wait_cnt == 8'd0);  // PC+4 written on the first fetch cycle only
            cw[13:12]    = 2'b11;
            cw[3:0]      = 4'b0100;
         end
         S_F2: cw[B_IR_EN] = 1'b1;
         S_DP: begin
            cw[B_RF_RW]  = (IR[24:23] != 2'b10);
            cw[3:0]      = IR[24:21];
            cw[B_SR_EN]  = IR[20];
            cw[5:4]      = IR[25] ? 2'b01 : 2'b00;
            cw[B_SHT_EN] = ~IR[25];
         end
         S_LS0: begin
            cw[B_MAR_EN] = 1'b1;
            cw[B_ISE_EN] = 1'b1;
            cw[3:0]      = IR[23] ? 4'b0100 : 4'b0010;
         end
         S_LD1: begin
            cw[B_MFA]    = 1'b1;
            cw[B_RW_RAM] = 1'b1;
            cw[B_MDR_EN] = 1'b1;
         end
         S_LD2: begin
            cw[B_RF_RW] = 1'b1;
            cw[15:14]   = 2'b01;
         end
         S_ST1: begin
            cw[B_MDR_EN] = 1'b1;
            cw[B_SMA]    = 1'b1;
            cw[9:8]      = 2'b01;
         end
         S_ST2: cw[B_MFA] = 1'b1;
         S_BL: begin
            cw[B_RF_RW] = 1'b1;
            cw[13:12]   = 2'b10;
            cw[3:0]     = 4'b1101;
         end
         S_B: begin
            cw[B_SGN_EN] = 1'b1;
            cw[B_RF_RW]  = 1'b1;
            cw[13:12]    = 2'b11;
            cw[3:0]      = 4'b0100;
         end
         default: cw = '0;
      endcase
   end

   assign CW    = cw;
   assign STATE = state;
   assign FAULT = (state == S_FAULT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues the expected STATE/CW/FAULT for
// every cycle it drives, and a negedge monitor pops and compares against the DUT.
module tb_control_unit;

   localparam logic [4:0] RST = 5'd0, F0 = 5'd1, F1 = 5'd2, F2 = 5'd3, DEC = 5'd4;
   localparam logic [4:0] DP = 5'd5, LS0 = 5'd6, LD1 = 5'd7, LD2 = 5'd8, ST1 = 5'd9;
   localparam logic [4:0] ST2 = 5'd10, BL = 5'd11, BB = 5'd12, FLT = 5'd31;

   localparam logic [31:0] CW_RST  = 32'h0001_0000;
   localparam logic [31:0] CW_F0   = 32'h0080_0C0D;
   localparam logic [31:0] CW_F1A  = 32'hD020_3004;
   localparam logic [31:0] CW_F1B  = 32'hC020_3004;
   localparam logic [31:0] CW_F2   = 32'h0010_0000;
   localparam logic [31:0] CW_ZERO = 32'h0000_0000;
   localparam logic [31:0] CW_ADDS = 32'h1048_0004;
   localparam logic [31:0] CW_CMP  = 32'h0040_001A;
   localparam logic [31:0] CW_LS0  = 32'h0084_0004;
   localparam logic [31:0] CW_LD1  = 32'hC020_0000;
   localparam logic [31:0] CW_LD2  = 32'h1000_4000;
   localparam logic [31:0] CW_ST1  = 32'h0220_0100;
   localparam logic [31:0] CW_ST2  = 32'h8000_0000;
   localparam logic [31:0] CW_BL   = 32'h1000_200D;
   localparam logic [31:0] CW_B    = 32'h1002_3004;

   localparam logic [31:0] IR_ADDS = 32'hE091_2003;
   localparam logic [31:0] IR_CMP  = 32'hE351_0005;
   localparam logic [31:0] IR_BEQ  = 32'h0A00_0004;
   localparam logic [31:0] IR_BNE  = 32'h1A00_0004;
   localparam logic [31:0] IR_BGE  = 32'hAA00_0004;
   localparam logic [31:0] IR_BL   = 32'hEB00_0010;
   localparam logic [31:0] IR_LDR  = 32'hE591_2004;
   localparam logic [31:0] IR_STR  = 32'hE581_2004;
   localparam logic [31:0] IR_UND  = 32'hE600_0010;

   typedef struct {
      logic [4:0]  st;
      logic [31:0] cw;
      logic        flt;
      string       tag;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] IR;
   logic        MFC;
   logic [3:0]  Flags;
   logic [31:0] CW;
   logic [4:0]  STATE;
   logic        FAULT;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   control_unit #(.MFC_TIMEOUT(4), .ST_W(5)) dut (
      .CLK(CLK), .RESET(RESET), .IR(IR), .MFC(MFC), .Flags(Flags),
      .CW(CW), .STATE(STATE), .FAULT(FAULT)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         if (STATE !== e.st || CW !== e.cw || FAULT !== e.flt) begin
            n_bad++;
            $display("FAIL %s: got STATE=%0d CW=%08h FAULT=%0b, want STATE=%0d CW=%08h FAULT=%0b",
                     e.tag, STATE, CW, FAULT, e.st, e.cw, e.flt);
         end
      end
   end

   task automatic step(input string tag, input logic rst, input logic mfc,
                       input logic [4:0] st, input logic [31:0] cw, input logic flt);
      exp_t e;
      RESET = rst;
      MFC   = mfc;
      e.st  = st;
      e.cw  = cw;
      e.flt = flt;
      e.tag = tag;
      sb.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic fetch(input string tag);
      step({tag, "_f0"}, 1'b0, 1'b0, F0, CW_F0, 1'b0);
      step({tag, "_f1"}, 1'b0, 1'b1, F1, CW_F1A, 1'b0);
      step({tag, "_f2"}, 1'b0, 1'b0, F2, CW_F2, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1;
      MFC   = 1'b0;
      IR    = IR_ADDS;
      Flags = 4'b0000;
      @(posedge CLK);
      #1;

      // reset, slow fetch, ADDS
      step("rst_hold", 1'b1, 1'b0, RST, CW_RST, 1'b0);
      step("rst_rel",  1'b0, 1'b0, RST, CW_RST, 1'b0);
      step("t1_f0",    1'b0, 1'b0, F0,  CW_F0,  1'b0);
      step("t1_f1_w0", 1'b0, 1'b0, F1,  CW_F1A, 1'b0);
      step("t1_f1_w1", 1'b0, 1'b0, F1,  CW_F1B, 1'b0);
      step("t1_f1_w2", 1'b0, 1'b0, F1,  CW_F1B, 1'b0);
      step("t1_f1_w3", 1'b0, 1'b1, F1,  CW_F1B, 1'b0);
      step("t1_f2",    1'b0, 1'b0, F2,  CW_F2,  1'b0);
      step("t1_dec",   1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("t1_dp",    1'b0, 1'b0, DP,  CW_ADDS, 1'b0);

      // ADDS with immediate MFC straight after reset: back to F0 after 5 edges
      step("t2_rst",     1'b1, 1'b0, F0,  CW_F0,  1'b0);
      step("t2_rst_rel", 1'b0, 1'b0, RST, CW_RST, 1'b0);
      fetch("t2");
      step("t2_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("t2_dp",  1'b0, 1'b0, DP,  CW_ADDS, 1'b0);

      // condition codes
      IR = IR_BEQ; Flags = 4'b0000;
      fetch("beq_fail");
      step("beq_fail_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      Flags = 4'b0100;
      fetch("beq_pass");
      step("beq_pass_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("beq_pass_b",   1'b0, 1'b0, BB,  CW_B,    1'b0);
      IR = IR_BNE; Flags = 4'b0100;
      fetch("bne_fail");
      step("bne_fail_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      IR = IR_BGE; Flags = 4'b1001;
      fetch("bge_pass");
      step("bge_pass_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("bge_pass_b",   1'b0, 1'b0, BB,  CW_B,    1'b0);

      // compare with immediate operand: flags only, no register write
      IR = IR_CMP; Flags = 4'b0000;
      fetch("cmp");
      step("cmp_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("cmp_dp",  1'b0, 1'b0, DP,  CW_CMP,  1'b0);

      // BL, LDR, STR
      IR = IR_BL;
      fetch("bl");
      step("bl_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("bl_bl",  1'b0, 1'b0, BL,  CW_BL,   1'b0);
      step("bl_b",   1'b0, 1'b0, BB,  CW_B,    1'b0);
      IR = IR_LDR;
      fetch("ldr");
      step("ldr_dec",    1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("ldr_ls0",    1'b0, 1'b0, LS0, CW_LS0,  1'b0);
      step("ldr_ld1_w0", 1'b0, 1'b0, LD1, CW_LD1,  1'b0);
      step("ldr_ld1_w1", 1'b0, 1'b1, LD1, CW_LD1,  1'b0);
      step("ldr_ld2",    1'b0, 1'b0, LD2, CW_LD2,  1'b0);
      IR = IR_STR;
      fetch("str");
      step("str_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("str_ls0", 1'b0, 1'b0, LS0, CW_LS0,  1'b0);
      step("str_st1", 1'b0, 1'b0, ST1, CW_ST1,  1'b0);
      step("str_st2", 1'b0, 1'b1, ST2, CW_ST2,  1'b0);

      // MFC timeout in F1 (limit 4): fault on the 5th wait edge
      IR = IR_ADDS;
      step("to_f0",    1'b0, 1'b0, F0,  CW_F0,   1'b0);
      step("to_f1_w0", 1'b0, 1'b0, F1,  CW_F1A,  1'b0);
      step("to_f1_w1", 1'b0, 1'b0, F1,  CW_F1B,  1'b0);
      step("to_f1_w2", 1'b0, 1'b0, F1,  CW_F1B,  1'b0);
      step("to_f1_w3", 1'b0, 1'b0, F1,  CW_F1B,  1'b0);
      step("to_f1_w4", 1'b0, 1'b0, F1,  CW_F1B,  1'b0);
      step("to_fault", 1'b0, 1'b1, FLT, CW_ZERO, 1'b1);
      step("to_hold",  1'b1, 1'b0, FLT, CW_ZERO, 1'b1);
      step("to_rst",   1'b0, 1'b0, RST, CW_RST,  1'b0);

      // MFC arrives exactly at the limit: no fault
      step("tw_f0",    1'b0, 1'b0, F0,  CW_F0,   1'b0);
      step("tw_f1_w0", 1'b0, 1'b0, F1,  CW_F1A,  1'b0);
      step("tw_f1_w1", 1'b0, 1'b0, F1,  CW_F1B,  1'b0);
      step("tw_f1_w2", 1'b0, 1'b0, F1,  CW_F1B,  1'b0);
      step("tw_f1_w3", 1'b0, 1'b0, F1,  CW_F1B,  1'b0);
      step("tw_f1_w4", 1'b0, 1'b1, F1,  CW_F1B,  1'b0);
      step("tw_f2",    1'b0, 1'b0, F2,  CW_F2,   1'b0);
      step("tw_dec",   1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("tw_dp",    1'b0, 1'b0, DP,  CW_ADDS, 1'b0);

      // undefined instruction
      IR = IR_UND;
      fetch("und");
      step("und_dec",   1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("und_fault", 1'b1, 1'b0, FLT, CW_ZERO, 1'b1);
      step("und_rst",   1'b0, 1'b0, RST, CW_RST,  1'b0);

      // reset in the middle of an LD1 wait
      IR = IR_LDR;
      fetch("mid");
      step("mid_dec",    1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("mid_ls0",    1'b0, 1'b0, LS0, CW_LS0,  1'b0);
      step("mid_ld1_w0", 1'b0, 1'b0, LD1, CW_LD1,  1'b0);
      step("mid_ld1_rs", 1'b1, 1'b0, LD1, CW_LD1,  1'b0);
      step("mid_rst",    1'b0, 1'b0, RST, CW_RST,  1'b0);
      fetch("mid_re");
      step("mid_re_dec", 1'b0, 1'b0, DEC, CW_ZERO, 1'b0);
      step("mid_re_ls0", 1'b0, 1'b0, LS0, CW_LS0,  1'b0);
      step("mid_re_ld1", 1'b0, 1'b1, LD1, CW_LD1,  1'b0);
      step("mid_re_ld2", 1'b0, 1'b0, LD2, CW_LD2,  1'b0);
      step("mid_re_f0",  1'b0, 1'b0, F0,  CW_F0,   1'b0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge CLK);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
